// File: rtl/mips_debug_controller.sv
// -----------------------------------------------------------------------------
// mips_debug_controller
//
// This is the command-driven debug sequencer for the MIPS core. It owns the
// pipeline-wide stall. It can run, halt and single-step the core, and it counts
// the cycles in which the core is not stalled. It can also dump the register
// file or the data memory through the core's debug read port. The dump and the
// cycle count leave as a little-endian byte stream toward the UART TX side.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   i_cmd_valid    host command byte valid
//   i_cmd          command byte: 'R' run, 'S' step, 'H' halt, 'D' dump regs,
//                  'M' dump memory, 'C' send cycle count
//   o_cmd_ready    command byte accepted when high together with i_cmd_valid
//   i_halt         halt instruction retired by the core
//   o_stall        core stall input (1 = frozen)
//   o_dbg_sel      debug read target: 0 = register file, 1 = data memory
//   o_dbg_addr     debug read word index
//   i_dbg_data     debug read data, valid one cycle after address/select change
//   o_tx_valid     output byte valid
//   o_tx_byte      output byte
//   i_tx_ready     byte sink ready
//   o_prog_done    sticky flag: the core reached i_halt
//   o_cycle_count  count of unstalled cycles since reset
// -----------------------------------------------------------------------------
module mips_debug_controller #(
  parameter int SIZE      = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  input  logic [7:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt,
  output logic              o_stall,
  output logic              o_dbg_sel,
  output logic [ADDR_W-1:0] o_dbg_addr,
  input  logic [SIZE-1:0]   i_dbg_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_ready,
  output logic              o_prog_done,
  output logic [SIZE-1:0]   o_cycle_count
);

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_DREG = 8'h44;
  localparam logic [7:0] CMD_DMEM = 8'h4D;
  localparam logic [7:0] CMD_CYC  = 8'h43;

  localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DUMP_ADDR,
    S_DUMP_WAIT,
    S_DUMP_SEND,
    S_CYC_SEND
  } state_t;

  state_t            state_q,       state_d;
  logic              stall_q,       stall_d;
  logic              cmd_ready_q,   cmd_ready_d;
  logic              dbg_sel_q,     dbg_sel_d;
  logic [ADDR_W-1:0] dbg_addr_q,    dbg_addr_d;
  logic [ADDR_W-1:0] index_q,       index_d;
  logic              tx_valid_q,    tx_valid_d;
  logic [7:0]        tx_byte_q,     tx_byte_d;
  logic [SIZE-1:0]   shift_q,       shift_d;
  logic [1:0]        byte_cnt_q,    byte_cnt_d;
  logic              prog_done_q,   prog_done_d;
  logic [SIZE-1:0]   cycle_count_q, cycle_count_d;

  logic              cmd_fire;
  logic              tx_fire;
  logic [ADDR_W-1:0] last_index;

  assign cmd_fire   = i_cmd_valid && cmd_ready_q;
  assign tx_fire    = tx_valid_q && i_tx_ready;
  assign last_index = dbg_sel_q ? MEM_LAST : REG_LAST;

  always_comb begin
    state_d       = state_q;
    dbg_sel_d     = dbg_sel_q;
    dbg_addr_d    = dbg_addr_q;
    index_d       = index_q;
    tx_valid_d    = tx_valid_q;
    tx_byte_d     = tx_byte_q;
    shift_d       = shift_q;
    byte_cnt_d    = byte_cnt_q;
    prog_done_d   = prog_done_q;

    // The count advances on every edge where the core was free to run.
    // Unsigned addition wraps naturally.
    cycle_count_d = stall_q ? cycle_count_q : cycle_count_q + SIZE'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_RUN: begin
              state_d     = S_RUN;
              prog_done_d = 1'b0;
            end
            CMD_STEP: state_d = S_STEP;
            CMD_DREG, CMD_DMEM: begin
              dbg_sel_d  = (i_cmd == CMD_DMEM);
              index_d    = '0;
              // The address is registered on entry. It is therefore already
              // stable during the DUMP_ADDR cycle, and the read data arrives
              // in DUMP_WAIT.
              dbg_addr_d = '0;
              state_d    = S_DUMP_ADDR;
            end
            CMD_CYC: begin
              // The core is stalled in IDLE, so the count is frozen here.
              tx_valid_d = 1'b1;
              tx_byte_d  = cycle_count_q[7:0];
              shift_d    = cycle_count_q >> 8;
              byte_cnt_d = 2'd0;
              state_d    = S_CYC_SEND;
            end
            default: ; // 'H' and unknown bytes are swallowed
          endcase
        end
      end

      S_RUN: begin
        // i_halt takes priority. A simultaneous 'H' also ends in IDLE.
        if (i_halt) begin
          prog_done_d = 1'b1;
          state_d     = S_IDLE;
        end else if (cmd_fire && (i_cmd == CMD_HALT)) begin
          state_d = S_IDLE;
        end
      end

      S_STEP: begin
        if (i_halt) prog_done_d = 1'b1;
        state_d = S_IDLE;
      end

      S_DUMP_ADDR: state_d = S_DUMP_WAIT;

      S_DUMP_WAIT: begin
        tx_valid_d = 1'b1;
        tx_byte_d  = i_dbg_data[7:0];
        shift_d    = i_dbg_data >> 8;
        byte_cnt_d = 2'd0;
        state_d    = S_DUMP_SEND;
      end

      S_DUMP_SEND, S_CYC_SEND: begin
        if (tx_fire) begin
          if (byte_cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            if (state_q == S_CYC_SEND || index_q == last_index) begin
              state_d = S_IDLE;
            end else begin
              index_d    = index_q + ADDR_W'(1);
              dbg_addr_d = index_q + ADDR_W'(1);
              state_d    = S_DUMP_ADDR;
            end
          end else begin
            // The next byte is presented on the cycle after the handshake.
            tx_byte_d  = shift_q[7:0];
            shift_d    = shift_q >> 8;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The stall and ready outputs are registered from the next state so that
    // they line up exactly with the state they describe.
    stall_d     = !((state_d == S_RUN) || (state_d == S_STEP));
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      stall_q       <= 1'b1;
      cmd_ready_q   <= 1'b0;
      dbg_sel_q     <= 1'b0;
      dbg_addr_q    <= '0;
      index_q       <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      shift_q       <= '0;
      byte_cnt_q    <= 2'd0;
      prog_done_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_q       <= stall_d;
      cmd_ready_q   <= cmd_ready_d;
      dbg_sel_q     <= dbg_sel_d;
      dbg_addr_q    <= dbg_addr_d;
      index_q       <= index_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      shift_q       <= shift_d;
      byte_cnt_q    <= byte_cnt_d;
      prog_done_q   <= prog_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign o_stall       = stall_q;
  assign o_cmd_ready   = cmd_ready_q;
  assign o_dbg_sel     = dbg_sel_q;
  assign o_dbg_addr    = dbg_addr_q;
  assign o_tx_valid    = tx_valid_q;
  assign o_tx_byte     = tx_byte_q;
  assign o_prog_done   = prog_done_q;
  assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips_debug_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_debug_controller
//
// Directed bench for mips_debug_controller. A registered read-port model
// returns 0x11223300 + address. Each accepted TX byte is collected into a queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_debug_controller;

  localparam int SIZE      = 32;
  localparam int NUM_REGS  = 32;
  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_cmd_valid = 1'b0;
  logic [7:0]        i_cmd = 8'h00;
  logic              o_cmd_ready;
  logic              i_halt = 1'b0;
  logic              o_stall;
  logic              o_dbg_sel;
  logic [ADDR_W-1:0] o_dbg_addr;
  logic [SIZE-1:0]   i_dbg_data = '0;
  logic              o_tx_valid;
  logic [7:0]        o_tx_byte;
  logic              i_tx_ready = 1'b0;
  logic              o_prog_done;
  logic [SIZE-1:0]   o_cycle_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  int         hold_viol = 0;
  int         sel_viol  = 0;
  logic       sel_watch = 1'b0;
  logic       exp_sel   = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  mips_debug_controller #(
    .SIZE(SIZE), .NUM_REGS(NUM_REGS), .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd        (i_cmd),
    .o_cmd_ready  (o_cmd_ready),
    .i_halt       (i_halt),
    .o_stall      (o_stall),
    .o_dbg_sel    (o_dbg_sel),
    .o_dbg_addr   (o_dbg_addr),
    .i_dbg_data   (i_dbg_data),
    .o_tx_valid   (o_tx_valid),
    .o_tx_byte    (o_tx_byte),
    .i_tx_ready   (i_tx_ready),
    .o_prog_done  (o_prog_done),
    .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  // Synchronous read port: data follows the address by one clock.
  always @(posedge clk) i_dbg_data <= 32'h11223300 + 32'(o_dbg_addr);

  // Byte collector plus handshake and select watchdogs.
  always @(posedge clk) begin
    if (rst) begin
      if (o_tx_valid && i_tx_ready) begin
        rx_q.push_back(o_tx_byte);
        $display("tx byte 0x%02h", o_tx_byte);
      end
      if (prev_valid && !prev_ready && !(o_tx_valid && o_tx_byte == prev_byte))
        hold_viol <= hold_viol + 1;
      if (sel_watch && (o_dbg_sel != exp_sel))
        sel_viol <= sel_viol + 1;
    end
    prev_valid <= rst && o_tx_valid;
    prev_ready <= i_tx_ready;
    prev_byte  <= o_tx_byte;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n;
    n = 0;
    while (!o_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("cmd_ready_before_cmd", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd       = b;
    tick();
    i_cmd_valid = 1'b0;
    $display("cmd 0x%02h issued", b);
  endtask

  // 'R', then i_halt sampled on the n-th edge after acceptance.
  task automatic run_for(input int n, output int low);
    send_cmd(8'h52);
    low = 0;
    for (int i = 0; i < n; i++) begin
      if (!o_stall) low++;
      if (i == n - 1) i_halt = 1'b1;
      tick();
    end
    i_halt = 1'b0;
  endtask

  initial begin
    int low;
    int n;
    int mism;
    logic [31:0] w;

    // ---------------- reset values ----------------
    repeat (3) tick();
    check_eq("rst_stall",     32'(o_stall),       32'd1);
    check_eq("rst_cmd_ready", 32'(o_cmd_ready),   32'd0);
    check_eq("rst_tx_valid",  32'(o_tx_valid),    32'd0);
    check_eq("rst_tx_byte",   32'(o_tx_byte),     32'd0);
    check_eq("rst_dbg_addr",  32'(o_dbg_addr),    32'd0);
    check_eq("rst_dbg_sel",   32'(o_dbg_sel),     32'd0);
    check_eq("rst_prog_done", 32'(o_prog_done),   32'd0);
    check_eq("rst_count",     o_cycle_count,      32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    i_tx_ready = 1'b1;

    // ---------------- three single steps ----------------
    low = 0;
    for (int k = 0; k < 3; k++) begin
      send_cmd(8'h53);
      repeat (3) begin
        if (!o_stall) low++;
        tick();
      end
    end
    check_eq("step_low_cycles", 32'(low), 32'd3);
    check_eq("step_count",      o_cycle_count, 32'd3);

    // ---------------- run 20 cycles, halt ----------------
    run_for(20, low);
    check_eq("run_low_cycles", 32'(low), 32'd20);
    check_eq("run_stall_after", 32'(o_stall), 32'd1);
    check_eq("run_prog_done", 32'(o_prog_done), 32'd1);
    check_eq("run_count", o_cycle_count, 32'd23);

    // ---------------- 'H' together with i_halt ----------------
    send_cmd(8'h52);
    repeat (4) tick();
    i_cmd_valid = 1'b1;
    i_cmd       = 8'h48;
    i_halt      = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_halt      = 1'b0;
    check_eq("hh_stall",     32'(o_stall),     32'd1);
    check_eq("hh_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check_eq("hh_prog_done", 32'(o_prog_done), 32'd1);
    check_eq("hh_count",     o_cycle_count,    32'd28);

    // ---------------- 'R' clears done; 'D' ignored in RUN; 'H' stops ----------
    send_cmd(8'h52);
    check_eq("r_clears_done", 32'(o_prog_done), 32'd0);
    i_cmd_valid = 1'b1;
    i_cmd       = 8'h44;
    tick();
    check_eq("run_ignores_d", 32'(o_stall), 32'd0);
    i_cmd = 8'h48;
    tick();
    i_cmd_valid = 1'b0;
    check_eq("h_stall",     32'(o_stall),     32'd1);
    check_eq("h_prog_done", 32'(o_prog_done), 32'd0);
    check_eq("h_count",     o_cycle_count,    32'd30);

    // ---------------- reach 300 cycles ----------------
    run_for(270, low);
    check_eq("count_300", o_cycle_count, 32'h0000012C);

    // ---------------- 'C' with 'R' offered during the send ----------------
    rx_q.delete();
    send_cmd(8'h43);
    i_cmd_valid = 1'b1;
    i_cmd       = 8'h52;
    check_eq("cyc_cmd_ready", 32'(o_cmd_ready), 32'd0);
    n = 0;
    while (rx_q.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    i_cmd_valid = 1'b0;
    check_eq("cyc_nbytes", 32'(rx_q.size()), 32'd4);
    if (rx_q.size() >= 4) begin
      check_eq("cyc_b0", 32'(rx_q[0]), 32'h2C);
      check_eq("cyc_b1", 32'(rx_q[1]), 32'h01);
      check_eq("cyc_b2", 32'(rx_q[2]), 32'h00);
      check_eq("cyc_b3", 32'(rx_q[3]), 32'h00);
    end
    tick();
    check_eq("cyc_r_not_taken", 32'(o_stall), 32'd1);
    check_eq("cyc_count_frozen", o_cycle_count, 32'h0000012C);

    // ---------------- register dump, ready toggling ----------------
    rx_q.delete();
    send_cmd(8'h44);
    exp_sel   = 1'b0;
    sel_watch = 1'b1;
    n = 0;
    while (rx_q.size() < 4 * NUM_REGS && n < 3000) begin
      i_tx_ready = ~i_tx_ready;
      tick();
      n++;
    end
    sel_watch  = 1'b0;
    i_tx_ready = 1'b1;
    check_eq("dump_nbytes", 32'(rx_q.size()), 32'(4 * NUM_REGS));
    check_eq("dump_end_ready", 32'(o_cmd_ready), 32'd1);
    check_eq("dump_end_valid", 32'(o_tx_valid), 32'd0);
    if (rx_q.size() == 4 * NUM_REGS) begin
      check_eq("dump_b0",   32'(rx_q[0]),   32'h00);
      check_eq("dump_b1",   32'(rx_q[1]),   32'h33);
      check_eq("dump_b2",   32'(rx_q[2]),   32'h22);
      check_eq("dump_b3",   32'(rx_q[3]),   32'h11);
      check_eq("dump_last", 32'(rx_q[127]), 32'h11);
      mism = 0;
      for (int i = 0; i < 4 * NUM_REGS; i++) begin
        w = 32'h11223300 + 32'(i / 4);
        if (rx_q[i] != w[8*(i%4) +: 8]) mism++;
      end
      check_eq("dump_all_bytes", 32'(mism), 32'd0);
    end
    tick();
    check_eq("dump_hold", 32'(hold_viol), 32'd0);
    check_eq("dump_sel",  32'(sel_viol),  32'd0);

    // ---------------- memory dump aborted by reset ----------------
    rx_q.delete();
    send_cmd(8'h4D);
    n = 0;
    while (rx_q.size() < 22 && n < 500) begin
      tick();
      n++;
    end
    check_eq("mem_pre_nbytes", 32'(rx_q.size()), 32'd22);
    check_eq("mem_pre_valid",  32'(o_tx_valid),  32'd1);
    check_eq("mem_pre_byte",   32'(o_tx_byte),   32'h22);
    check_eq("mem_pre_addr",   32'(o_dbg_addr),  32'd5);
    check_eq("mem_pre_sel",    32'(o_dbg_sel),   32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_valid", 32'(o_tx_valid),  32'd0);
    check_eq("abort_stall", 32'(o_stall),     32'd1);
    check_eq("abort_byte",  32'(o_tx_byte),   32'd0);
    check_eq("abort_addr",  32'(o_dbg_addr),  32'd0);
    check_eq("abort_sel",   32'(o_dbg_sel),   32'd0);
    check_eq("abort_count", o_cycle_count,    32'd0);
    check_eq("abort_ready", 32'(o_cmd_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    // i_halt outside RUN/STEP has no effect.
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    check_eq("idle_halt_ignored", 32'(o_prog_done), 32'd0);

    rx_q.delete();
    send_cmd(8'h4D);
    check_eq("mem_restart_addr", 32'(o_dbg_addr), 32'd0);
    check_eq("mem_restart_sel",  32'(o_dbg_sel),  32'd1);
    n = 0;
    while (rx_q.size() < 8 && n < 200) begin
      tick();
      n++;
    end
    check_eq("mem_nbytes", 32'(rx_q.size() >= 8), 32'd1);
    if (rx_q.size() >= 8) begin
      check_eq("mem_b0", 32'(rx_q[0]), 32'h00);
      check_eq("mem_b1", 32'(rx_q[1]), 32'h33);
      check_eq("mem_b2", 32'(rx_q[2]), 32'h22);
      check_eq("mem_b3", 32'(rx_q[3]), 32'h11);
      check_eq("mem_b4", 32'(rx_q[4]), 32'h01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
